stack_op_controller: RTL and testbench
======================================

Name: stack_op_controller

Overview:
- Sequences all stack operations (push, pop, set-SP) for the CPU core.
- Owns the only write path into stack_addr_register: it computes the new stack pointer and drives the register's 4-bit command with code 4'h5 for exactly one cycle.
- Performs the matching data-memory access through a req/ack handshake and reports completion or fault to the decoder/sequencer.
- The stack grows downward; STACK_TOP is the empty-stack address.

Parameters:
- STACK_TOP, 32'h0000_0999, empty-stack SP value and upper bound for SP.
- STACK_LIMIT, 32'h0000_0100, lowest legal SP value.
- WORD_BYTES, 4, SP step per push/pop.
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ack before faulting.

Ports:
- clock_4  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request from the sequencer.
- op_kind  in  2  00 push, 01 pop, 10 set_sp, 11 reserved.
- op_data  in  32  push data, or the new SP value for set_sp.
- op_ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  qualifies done; operation aborted, no SP change.
- pop_data  out  32  popped word; valid while done=1 for a pop, held until the next pop.
- sp_in  in  32  current stack_addr value.
- sp_rw_code  out  4  command to stack_addr_register: 4'h5 = write, else 4'h0.
- sp_wdata  out  32  new SP value.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write (push), 0 = read (pop).
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.

Behaviour:
- Reset: all outputs are 0 except op_ready=1. Any operation in flight is abandoned: mem_req drops on the next edge, there is no commit and no done.
- States: IDLE, MEM, COMMIT, DONE, FAULT.
- IDLE:
  - An operation is accepted when op_valid=1, which is legal because op_ready=1 in IDLE.
  - On acceptance the controller latches op_kind, op_data and a snapshot sp_s = sp_in.
  - The next SP (sp_n) is computed in the accept cycle using 32-bit unsigned arithmetic.
- Push:
  - sp_n = sp_s - WORD_BYTES.
  - If sp_s < STACK_LIMIT + WORD_BYTES -> FAULT (overflow). The check is written in this form so it never wraps.
  - Otherwise -> MEM with mem_we=1, mem_addr=sp_n, mem_wdata=op_data.
- Pop:
  - sp_n = sp_s + WORD_BYTES.
  - If sp_s > STACK_TOP - WORD_BYTES -> FAULT (underflow).
  - Otherwise -> MEM with mem_we=0, mem_addr=sp_s.
- set_sp:
  - If op_data < STACK_LIMIT or op_data > STACK_TOP -> FAULT.
  - Otherwise sp_n = op_data -> COMMIT directly, with no memory access.
- op_kind=11 -> FAULT.
- MEM:
  - mem_req=1 and mem_we, mem_addr, mem_wdata are held stable.
  - A timeout counter starts at 0 on entry and increments every cycle.
  - When mem_ack=1: capture mem_rdata into pop_data for a pop, drop mem_req on the next edge, go to COMMIT.
  - When the counter reaches MEM_TIMEOUT-1 with no ack: go to FAULT with no commit.
  - An ack in the same cycle as the final count wins (the operation completes).
- COMMIT:
  - Lasts exactly one cycle: sp_rw_code=4'h5, sp_wdata=sp_n.
  - The register captures on the following negedge, so sp_in shows sp_n by the next posedge.
  - Outside COMMIT, sp_rw_code=4'h0 always.
- DONE: done=1, fault=0 for one cycle, then IDLE.
- FAULT: done=1, fault=1 for one cycle, then IDLE. SP and memory are untouched.
- Throughput: back-to-back ops are accepted in the cycle after DONE/FAULT.
- Latency from accept edge to done:
  - Push/pop: 3 + k cycles, where k = wait cycles before mem_ack.
  - set_sp: 2 cycles.
  - Fault at accept: 1 cycle.
- op_valid and op_data are ignored outside IDLE.
- The sp_s snapshot is used throughout the operation; changes on sp_in mid-operation are ignored.

Decomposition:
- Shared package stack_pkg:
  - op_kind encodings (OP_PUSH, OP_POP, OP_SETSP).
  - SP_CMD_WRITE = 4'h5 and SP_CMD_NONE = 4'h0 (also used by stack_addr_register).
  - State enum.
  - Default STACK_TOP and STACK_LIMIT.
- One natural sub-module, stack_bounds_check: combinational; takes kind, sp_s and op_data; outputs sp_n and a fault flag.
- FSM, timeout counter and handshake stay in the top level.

Test Plan:
- Reset then push 32'hDEAD_BEEF with sp_in=0x999 and ack after 2 cycles -> mem write to 0x995; one cycle of sp_rw_code=4'h5 with sp_wdata=0x995; done=1, fault=0; latency 5.
- Pop at sp_in=0x995 with mem_rdata=32'h1234_5678 and immediate ack -> read at 0x995; sp_wdata=0x999; pop_data=32'h1234_5678 at done.
- Pop at sp_in=0x999 -> done=1, fault=1 one cycle after accept; mem_req never asserted; sp_rw_code stays 0.
- Push at sp_in=0x103 -> overflow fault. set_sp 0x0FF -> fault. set_sp 0x500 -> commit 0x500 with no mem_req.
- Push with mem_ack never asserted -> mem_req held 16 cycles, then done with fault; no SP write.
- Reset asserted during MEM -> mem_req low after that edge, no done, no sp_rw_code=5; op_ready=1 next cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack operation controller and the stack address register.
package stack_pkg;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_SETSP = 2'b10;

  localparam logic [3:0] SP_CMD_WRITE = 4'h5;
  localparam logic [3:0] SP_CMD_NONE  = 4'h0;

  localparam logic [31:0] DEF_STACK_TOP   = 32'h0000_0999;
  localparam logic [31:0] DEF_STACK_LIMIT = 32'h0000_0100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM    = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational next-SP computation and legality check for one stack operation.
module stack_bounds_check
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = DEF_STACK_TOP,
  parameter logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT,
  parameter logic [31:0] WORD_BYTES  = 32'd4
) (
  input  logic [1:0]  kind,
  input  logic [31:0] sp_s,
  input  logic [31:0] op_data,
  output logic [31:0] sp_n,
  output logic        fault
);

  // Bounds are compared against constants rearranged so nothing can wrap.
  always_comb begin
    sp_n  = sp_s;
    fault = 1'b0;
    case (kind)
      OP_PUSH: begin
        sp_n  = sp_s - WORD_BYTES;
        fault = (sp_s < (STACK_LIMIT + WORD_BYTES));
      end
      OP_POP: begin
        sp_n  = sp_s + WORD_BYTES;
        fault = (sp_s > (STACK_TOP - WORD_BYTES));
      end
      OP_SETSP: begin
        sp_n  = op_data;
        fault = (op_data < STACK_LIMIT) || (op_data > STACK_TOP);
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/stack_op_controller.sv
// Sequences push/pop/set-SP: bounds check, memory handshake with timeout, single-cycle SP commit.
module stack_op_controller
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = DEF_STACK_TOP,
  parameter logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT,
  parameter logic [31:0] WORD_BYTES  = 32'd4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock_4,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_kind,
  input  logic [31:0] op_data,
  output logic        op_ready,
  output logic        done,
  output logic        fault,
  output logic [31:0] pop_data,
  input  logic [31:0] sp_in,
  output logic [3:0]  sp_rw_code,
  output logic [31:0] sp_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sp_n_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [31:0]      pop_data_q;

  logic [31:0] chk_sp_n;
  logic        chk_fault;

  stack_bounds_check #(
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT),
    .WORD_BYTES  (WORD_BYTES)
  ) u_bounds (
    .kind    (op_kind),
    .sp_s    (sp_in),
    .op_data (op_data),
    .sp_n    (chk_sp_n),
    .fault   (chk_fault)
  );

  // Everything derived from the accept-cycle sp_in snapshot is captured here; sp_in is not read again.
  always_ff @(posedge clock_4) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sp_n_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      pop_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            sp_n_q  <= chk_sp_n;
            we_q    <= (op_kind == OP_PUSH);
            addr_q  <= (op_kind == OP_PUSH) ? chk_sp_n : sp_in;
            wdata_q <= op_data;
            cnt     <= '0;
            if (chk_fault)
              state <= ST_FAULT;
            else if (op_kind == OP_SETSP)
              state <= ST_COMMIT;
            else
              state <= ST_MEM;
          end
        end
        ST_MEM: begin
          // An ack on the final count still completes the operation.
          if (mem_ack) begin
            if (!we_q)
              pop_data_q <= mem_rdata;
            state <= ST_COMMIT;
          end else if (cnt == CNT_LAST) begin
            state <= ST_FAULT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        ST_FAULT:  state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready   = (state == ST_IDLE);
  assign done       = (state == ST_DONE) || (state == ST_FAULT);
  assign fault      = (state == ST_FAULT);
  assign pop_data   = pop_data_q;
  assign sp_rw_code = (state == ST_COMMIT) ? SP_CMD_WRITE : SP_CMD_NONE;
  assign sp_wdata   = (state == ST_COMMIT) ? sp_n_q : '0;
  assign mem_req    = (state == ST_MEM);
  assign mem_we     = (state == ST_MEM) && we_q;
  assign mem_addr   = (state == ST_MEM) ? addr_q : '0;
  assign mem_wdata  = (state == ST_MEM) ? wdata_q : '0;

endmodule

// File: tb/tb_stack_op_controller.sv
// Randomized bench for stack_op_controller against a rule-level model of stack operations.
module tb_stack_op_controller;
  import stack_pkg::*;

  localparam logic [31:0] TOP = 32'h0000_0999;
  localparam logic [31:0] LIM = 32'h0000_0100;
  localparam logic [31:0] WB  = 32'd4;
  localparam int          TMO = 16;

  logic        clock_4 = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_kind = 2'b00;
  logic [31:0] op_data = '0;
  logic        op_ready, done, fault;
  logic [31:0] pop_data;
  logic [31:0] sp_in;
  logic [3:0]  sp_rw_code;
  logic [31:0] sp_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic [31:0] sp_reg = TOP;
  logic [31:0] sp_junk = '0;
  logic        perturb = 1'b0;
  assign sp_in = perturb ? sp_junk : sp_reg;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_pop = '0;
  logic [31:0] mem_model [logic [31:0]];

  stack_op_controller dut (
    .clock_4    (clock_4),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_kind    (op_kind),
    .op_data    (op_data),
    .op_ready   (op_ready),
    .done       (done),
    .fault      (fault),
    .pop_data   (pop_data),
    .sp_in      (sp_in),
    .sp_rw_code (sp_rw_code),
    .sp_wdata   (sp_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clock_4 = ~clock_4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation: model predicts outcome, bench plays memory and the SP register.
  task automatic run_op(input logic [1:0] kind, input logic [31:0] data, input int ack_delay);
    logic [31:0] sp0, e_addr, e_sp, e_pop, rd, got_sp, got_pop;
    longint      s, d;
    bit          acc_fault, e_mem, e_we, e_to, e_fault, seen, got_fault;
    int          e_lat, cyc, reqs, writes, mem_bad;
    sp0 = sp_reg; s = sp0; d = data;
    acc_fault = 0; e_mem = 0; e_we = 0; e_addr = '0; e_sp = sp0; rd = '0;
    case (kind)
      2'd0: if (s - 4 < 256) acc_fault = 1;
            else begin e_mem = 1; e_we = 1; e_addr = sp0 - WB; e_sp = sp0 - WB; end
      2'd1: if (s + 4 > 2457) acc_fault = 1;
            else begin e_mem = 1; e_addr = sp0; e_sp = sp0 + WB; end
      2'd2: if (d < 256 || d > 2457) acc_fault = 1;
            else e_sp = data;
      default: acc_fault = 1;
    endcase
    e_to    = e_mem && (ack_delay >= TMO);
    e_fault = acc_fault || e_to;
    if (acc_fault) e_lat = 1;
    else if (!e_mem) e_lat = 2;
    else if (e_to) e_lat = TMO + 1;
    else e_lat = 3 + ack_delay;
    e_pop = last_pop;
    if (e_mem && !e_we && !e_to) begin
      if (!mem_model.exists(e_addr)) mem_model[e_addr] = $urandom;
      rd = mem_model[e_addr];
      e_pop = rd;
    end

    @(negedge clock_4);
    chk("op_ready_idle", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op_kind = kind; op_data = data;
    @(posedge clock_4);
    #1;
    op_valid = 1'($urandom_range(0, 1)); op_kind = 2'($urandom); op_data = $urandom;
    perturb = 1'b1; sp_junk = $urandom;

    cyc = 0; reqs = 0; writes = 0; mem_bad = 0; seen = 0;
    got_fault = 0; got_sp = '0; got_pop = '0;
    while (!seen && cyc < 60) begin
      @(negedge clock_4);
      cyc++;
      if (mem_req) begin
        reqs++;
        if (mem_addr !== e_addr || mem_we !== e_we || (e_we && mem_wdata !== data)) mem_bad++;
        if (reqs == ack_delay + 1) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
      end else begin
        mem_ack = 1'b0;
      end
      if (sp_rw_code !== SP_CMD_NONE) begin
        writes++;
        got_sp = sp_wdata;
        if (sp_rw_code === SP_CMD_WRITE) sp_reg = sp_wdata;
      end
      if (done === 1'b1) begin
        seen = 1; got_fault = fault; got_pop = pop_data;
        op_valid = 1'b0;
      end
    end
    mem_ack = 1'b0; op_valid = 1'b0; perturb = 1'b0;

    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", cyc, e_lat);
    chk("fault", {31'd0, got_fault}, {31'd0, e_fault});
    chk("sp_writes", writes, e_fault ? 0 : 1);
    if (!e_fault) chk("sp_wdata", got_sp, e_sp);
    chk("mem_reqs", reqs, e_mem ? (e_to ? TMO : ack_delay + 1) : 0);
    chk("mem_stable", mem_bad, 0);
    chk("pop_data", got_pop, e_pop);
    chk("sp_after", sp_reg, e_fault ? sp0 : e_sp);

    if (!e_fault && e_mem && e_we) mem_model[e_addr] = data;
    last_pop = e_pop;
  endtask

  task automatic reset_mid_op();
    int bad;
    @(negedge clock_4);
    op_valid = 1'b1; op_kind = OP_PUSH; op_data = $urandom;
    @(posedge clock_4);
    #1 op_valid = 1'b0;
    repeat (4) @(negedge clock_4);
    chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock_4);
    #1 reset = 1'b0;
    @(negedge clock_4);
    chk("rst_req_low", {31'd0, mem_req}, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_pop_data", pop_data, 32'd0);
    bad = 0;
    repeat (4) begin
      if (done !== 1'b0 || sp_rw_code !== SP_CMD_NONE || mem_req !== 1'b0) bad++;
      @(negedge clock_4);
    end
    chk("rst_quiet", bad, 0);
    last_pop = '0;
  endtask

  initial begin
    logic [1:0]  k;
    logic [31:0] dat;
    int          dly;
    reset = 1'b1;
    repeat (3) @(posedge clock_4);
    @(negedge clock_4);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pop", pop_data, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_sp_code", {28'd0, sp_rw_code}, 32'd0);
    chk("rst_sp_wdata", sp_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    run_op(OP_PUSH, 32'hDEAD_BEEF, 2);
    mem_model[32'h995] = 32'h1234_5678;
    run_op(OP_POP, 32'h0, 0);
    run_op(OP_POP, 32'h0, 0);
    run_op(OP_SETSP, 32'h103, 0);
    run_op(OP_PUSH, 32'hAAAA_5555, 0);
    run_op(OP_SETSP, 32'h0FF, 0);
    run_op(OP_SETSP, 32'h500, 0);
    run_op(OP_PUSH, 32'h0BAD_F00D, 100);
    run_op(OP_PUSH, 32'h1111_2222, 15);
    run_op(OP_SETSP, 32'h104, 0);
    run_op(OP_PUSH, 32'h3333_4444, 1);
    run_op(OP_PUSH, 32'h5555_6666, 0);
    run_op(OP_SETSP, 32'h996, 0);
    run_op(OP_POP, 32'h0, 0);
    run_op(OP_SETSP, 32'h995, 0);
    run_op(OP_POP, 32'h0, 3);
    run_op(OP_SETSP, 32'h99A, 0);
    run_op(2'b11, 32'h0, 0);

    for (int i = 0; i < 180; i++) begin
      k = 2'($urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 5) < 4 ? 1 : $urandom_range(2, 3)));
      if ($urandom_range(0, 3) == 0) dat = $urandom;
      else dat = $urandom_range(32'h0F8, 32'h9A0);
      case ($urandom_range(0, 9))
        0: dly = 15;
        1: dly = 16 + $urandom_range(0, 4);
        default: dly = $urandom_range(0, 4);
      endcase
      run_op(k, dat, dly);
    end

    run_op(OP_SETSP, 32'h800, 0);
    reset_mid_op();
    run_op(OP_SETSP, 32'h600, 0);
    run_op(OP_PUSH, 32'hCAFE_0001, 0);
    run_op(OP_POP, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
